// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register: a two-entry skid buffer between fetch and decode.
// Holds bundles under decode back-pressure, drops them on flush and counts kills.
module ifid_skid_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IF_valid,
  output logic             IF_ready,
  input  logic [XLEN-1:0]  IF_PC,
  input  logic [XLEN-1:0]  IF_PC_link,
  input  logic [XLEN-1:0]  IF_instr,
  output logic             ID_valid,
  input  logic             ID_ready,
  output logic [XLEN-1:0]  ID_PC,
  output logic [XLEN-1:0]  ID_PC_link,
  output logic [XLEN-1:0]  ID_instr,
  input  logic             FLUSH,
  output logic [1:0]       COUNT,
  output logic [CNT_W-1:0] KILL_CNT
);

  localparam int NFIELD = 3;  // PC, link PC, instruction

  logic             r_m_valid;
  logic             r_s_valid;
  logic [CNT_W-1:0] r_kill_cnt;
  logic [XLEN-1:0]  r_m_pay [NFIELD];
  logic [XLEN-1:0]  r_s_pay [NFIELD];
  logic [XLEN-1:0]  w_if_pay [NFIELD];

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_m_take;
  logic             w_s_load;
  logic [1:0]       w_occupancy;
  logic [1:0]       w_kill_inc;
  logic [CNT_W:0]   w_kill_sum;
  logic [CNT_W-1:0] w_kill_next;

  assign w_if_pay[0] = IF_PC;
  assign w_if_pay[1] = IF_PC_link;
  assign w_if_pay[2] = IF_instr;

  // Ready looks only at the skid slot, so it never combinationally follows ID_ready.
  assign IF_ready   = EN & ~r_s_valid & ~RST;
  assign w_in_xfer  = IF_valid & IF_ready;
  assign w_out_xfer = r_m_valid & ID_ready & EN;

  // M refills whenever it is empty or being drained; otherwise a new bundle skids into S.
  assign w_m_take = ~r_m_valid | w_out_xfer;
  assign w_s_load = ~w_m_take & w_in_xfer;

  assign w_occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign w_kill_inc  = w_occupancy + {1'b0, w_in_xfer};
  assign w_kill_sum  = {1'b0, r_kill_cnt} + {{(CNT_W-1){1'b0}}, w_kill_inc};
  assign w_kill_next = w_kill_sum[CNT_W] ? {CNT_W{1'b1}} : w_kill_sum[CNT_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_kill_cnt <= '0;
    end else if (EN) begin
      if (FLUSH) begin
        r_m_valid  <= 1'b0;
        r_s_valid  <= 1'b0;
        r_kill_cnt <= w_kill_next;
      end else if (w_m_take) begin
        if (r_s_valid) begin
          r_m_valid <= 1'b1;
          r_s_valid <= 1'b0;
        end else begin
          r_m_valid <= w_in_xfer;
        end
      end else if (w_in_xfer) begin
        r_s_valid <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NFIELD; gi++) begin : g_field
      // Payload only moves on a real capture; contents with valid=0 are stale.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_m_pay[gi] <= '0;
          r_s_pay[gi] <= '0;
        end else if (EN && !FLUSH) begin
          if (w_m_take) begin
            if (r_s_valid) begin
              r_m_pay[gi] <= r_s_pay[gi];
            end else if (w_in_xfer) begin
              r_m_pay[gi] <= w_if_pay[gi];
            end
          end else if (w_s_load) begin
            r_s_pay[gi] <= w_if_pay[gi];
          end
        end
      end
    end
  endgenerate

  assign ID_valid   = r_m_valid;
  assign ID_PC      = r_m_pay[0];
  assign ID_PC_link = r_m_pay[1];
  assign ID_instr   = r_m_pay[2];
  assign COUNT      = w_occupancy;
  assign KILL_CNT   = r_kill_cnt;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer.
module tb_ifid_skid_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int KMAX  = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RST;
  logic             EN;
  logic             IF_valid;
  logic             IF_ready;
  logic [XLEN-1:0]  IF_PC;
  logic [XLEN-1:0]  IF_PC_link;
  logic [XLEN-1:0]  IF_instr;
  logic             ID_valid;
  logic             ID_ready;
  logic [XLEN-1:0]  ID_PC;
  logic [XLEN-1:0]  ID_PC_link;
  logic [XLEN-1:0]  ID_instr;
  logic             FLUSH;
  logic [1:0]       COUNT;
  logic [CNT_W-1:0] KILL_CNT;

  ifid_skid_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .IF_valid(IF_valid), .IF_ready(IF_ready),
    .IF_PC(IF_PC), .IF_PC_link(IF_PC_link), .IF_instr(IF_instr),
    .ID_valid(ID_valid), .ID_ready(ID_ready),
    .ID_PC(ID_PC), .ID_PC_link(ID_PC_link), .ID_instr(ID_instr),
    .FLUSH(FLUSH), .COUNT(COUNT), .KILL_CNT(KILL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] instr;
  } bundle_t;

  // Model: FIFO of accepted bundles (capacity 2) and a saturating kill count.
  bundle_t q[$];
  int      m_kill;
  int      n_checks;
  int      n_pass;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit en, input bit rst, input bit iv, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] instr, input bit idr, input bit fl);
    bit exp_rdy, in_x, out_x;
    bundle_t b;
    EN = en; RST = rst; IF_valid = iv; IF_PC = pc; IF_PC_link = pc + 32'd4;
    IF_instr = instr; ID_ready = idr; FLUSH = fl;
    @(negedge CLK);
    exp_rdy = en && !rst && (q.size() < 2);
    check_eq("if_ready", 64'(IF_ready), 64'(exp_rdy));
    check_eq("id_valid", 64'(ID_valid), 64'(q.size() > 0));
    check_eq("count",    64'(COUNT),    64'(q.size()));
    check_eq("kill_cnt", 64'(KILL_CNT), 64'(m_kill));
    if (q.size() > 0) begin
      check_eq("id_pc",    64'(ID_PC),      64'(q[0].pc));
      check_eq("id_link",  64'(ID_PC_link), 64'(q[0].link));
      check_eq("id_instr", 64'(ID_instr),   64'(q[0].instr));
    end
    in_x  = iv && exp_rdy;
    out_x = (q.size() > 0) && idr && en;
    b.pc = pc; b.link = pc + 32'd4; b.instr = instr;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_kill = 0;
    end else if (en) begin
      if (fl) begin
        m_kill = m_kill + q.size() + int'(in_x);
        if (m_kill > KMAX) m_kill = KMAX;
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(b);
      end
    end
    $display("cyc en=%0d rst=%0d iv=%0d pc=%08h idr=%0d fl=%0d -> occ=%0d kill=%0d",
             en, rst, iv, pc, idr, fl, q.size(), m_kill);
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_kill = 0;
    EN = 1'b1; RST = 1'b1; IF_valid = 1'b1; IF_PC = '0; IF_PC_link = 32'd4;
    IF_instr = '0; ID_ready = 1'b0; FLUSH = 1'b0;
    @(posedge CLK); #1;

    // Reset held with a valid bundle offered
    step(1, 1, 1, 32'h0, 32'h13, 0, 0);
    check_eq("rst_pc",    64'(ID_PC),      64'd0);
    check_eq("rst_link",  64'(ID_PC_link), 64'd0);
    check_eq("rst_instr", 64'(ID_instr),   64'd0);
    step(1, 1, 1, 32'h0, 32'h13, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);

    // Back-to-back streaming
    step(1, 0, 1, 32'h0, 32'h00000013, 1, 0);
    step(1, 0, 1, 32'h4, 32'h00100093, 1, 0);
    step(1, 0, 1, 32'h8, 32'h00200113, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: third bundle held off until S drains
    step(1, 0, 1, 32'h0, 32'h00000013, 0, 0);
    step(1, 0, 1, 32'h4, 32'h00100093, 0, 0);
    step(1, 0, 1, 32'h8, 32'h00200113, 0, 0);
    step(1, 0, 1, 32'h8, 32'h00200113, 0, 0);
    step(1, 0, 1, 32'h8, 32'h00200113, 1, 0);
    step(1, 0, 1, 32'h8, 32'h00200113, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1, 0);

    // Flush a full buffer, then flush one held plus one incoming
    step(1, 0, 1, 32'h100, 32'hA1, 0, 0);
    step(1, 0, 1, 32'h104, 32'hA2, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    step(1, 0, 1, 32'h0C, 32'hA3, 0, 0);
    step(1, 0, 1, 32'h10, 32'hA4, 0, 1);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);

    // Enable freeze with M holding 0x20
    step(1, 0, 1, 32'h20, 32'hB0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h24, 32'hB1, 1, 0);
    step(1, 0, 1, 32'h24, 32'hB1, 1, 0);
    step(1, 0, 1, 32'h28, 32'hB2, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);

    // Kill counter saturation via repeated full-buffer flushes
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 32'h200 + 32'(i * 8), 32'hC0, 0, 0);
      step(1, 0, 1, 32'h204 + 32'(i * 8), 32'hC1, 0, 0);
      step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    end
    check_eq("kill_sat", 64'(KILL_CNT), 64'hF);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7), {$urandom_range(0, 65535), 2'b00},
           $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
